// File: rtl/blit_byte_sequencer.sv
// ---------------------------------------------------------------------------
// blit_byte_sequencer
//
// Blitter inner-loop byte sequencer. For every byte of a run it optionally
// reads the source, optionally reads the destination, combines the two bytes
// through a per-bit 4-minterm logic function and writes the result back. The
// memory interface has one outstanding request at a time. A request is held
// until MEM_ACK. Read data is captured in the ACK cycle.
//
// Optional feature (compile-time macro BLIT_CMP_INHIBIT_EN):
//   When the macro is defined, the inputs CMPEN/CMPVAL are added. A byte whose
//   source latch equals CMPVAL (with CMPEN=1) is not written. It is still
//   counted, and ADV_DST still pulses. When the macro is undefined, every byte
//   is written.
//
// Parameters
//   DW  data width (number of logic-function bit slices)
//   CW  inner-count width; INNER_CNT==0 runs 2**CW bytes
//
// Ports
//   CLK        in   system clock, rising edge
//   RESET      in   asynchronous active-high reset
//   START      in   run request pulse; accepted only in IDLE
//   INNER_CNT  in   bytes per run, sampled on accepted START
//   SRCEN      in   read source per byte (else reuse held source latch)
//   DSTEN      in   read destination per byte (else destination = 0)
//   LFUC       in   minterm enables {SD,S~D,~SD,~S~D}, sampled on START
//   CMPEN      in   (BLIT_CMP_INHIBIT_EN only) write-inhibit compare enable
//   CMPVAL     in   (BLIT_CMP_INHIBIT_EN only) write-inhibit compare value
//   MEM_RD     out  read request, held until MEM_ACK
//   MEM_WR     out  write request, held until MEM_ACK
//   MEM_SEL    out  0 = source address, 1 = destination address
//   MEM_ACK    in   access complete (read data valid in same cycle)
//   MEM_DIN    in   read data
//   MEM_DOUT   out  write data, registered on entry to the write state
//   ADV_SRC    out  source address advance (ACK of a source read)
//   ADV_DST    out  destination address advance (completion of a write)
//   BUSY       out  run in progress
//   DONE       out  one-cycle end-of-run pulse
// ---------------------------------------------------------------------------
module blit_byte_sequencer #(
    parameter int DW = 8,
    parameter int CW = 9
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          START,
    input  logic [CW-1:0] INNER_CNT,
    input  logic          SRCEN,
    input  logic          DSTEN,
    input  logic [3:0]    LFUC,
`ifdef BLIT_CMP_INHIBIT_EN
    input  logic          CMPEN,
    input  logic [DW-1:0] CMPVAL,
`endif
    output logic          MEM_RD,
    output logic          MEM_WR,
    output logic          MEM_SEL,
    input  logic          MEM_ACK,
    input  logic [DW-1:0] MEM_DIN,
    output logic [DW-1:0] MEM_DOUT,
    output logic          ADV_SRC,
    output logic          ADV_DST,
    output logic          BUSY,
    output logic          DONE
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RSRC,
        S_RDST,
        S_WR,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] src_q, src_d;
    logic [DW-1:0] dst_q, dst_d;
    logic [DW-1:0] dout_q, dout_d;
    logic [3:0]    lfuc_q, lfuc_d;
    logic          srcen_q, srcen_d;
    logic          dsten_q, dsten_d;
    logic          wr_skip;
    logic          wr_fire;

    // Per-bit logic function: each LFUC bit enables one minterm of (S,D).
    function automatic logic [DW-1:0] lfu(input logic [3:0]    c,
                                          input logic [DW-1:0] s,
                                          input logic [DW-1:0] d);
        lfu = ({DW{c[3]}} &  s &  d) |
              ({DW{c[2]}} &  s & ~d) |
              ({DW{c[1]}} & ~s &  d) |
              ({DW{c[0]}} & ~s & ~d);
    endfunction

    // First state of each byte: the first enabled read, or straight to write.
    function automatic state_t first_state(input logic src_en, input logic dst_en);
        if (src_en) begin
            first_state = S_RSRC;
        end else if (dst_en) begin
            first_state = S_RDST;
        end else begin
            first_state = S_WR;
        end
    endfunction

`ifdef BLIT_CMP_INHIBIT_EN
    assign wr_skip = CMPEN && (src_q == CMPVAL);
`else
    assign wr_skip = 1'b0;
`endif

    // A skipped write completes immediately because no request is issued
    // and therefore no ACK will arrive.
    assign wr_fire  = (state_q == S_WR) && (MEM_ACK || wr_skip);
    assign MEM_DOUT = dout_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            dout_q  <= '0;
            lfuc_q  <= '0;
            srcen_q <= 1'b0;
            dsten_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            dout_q  <= dout_d;
            lfuc_q  <= lfuc_d;
            srcen_q <= srcen_d;
            dsten_q <= dsten_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        dst_d   = dst_q;
        dout_d  = dout_q;
        lfuc_d  = lfuc_q;
        srcen_d = srcen_q;
        dsten_d = dsten_q;
        MEM_RD  = 1'b0;
        MEM_WR  = 1'b0;
        MEM_SEL = 1'b0;
        ADV_SRC = 1'b0;
        ADV_DST = 1'b0;
        DONE    = 1'b0;
        BUSY    = (state_q == S_RSRC) || (state_q == S_RDST) || (state_q == S_WR);

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    cnt_d   = INNER_CNT;
                    lfuc_d  = LFUC;
                    srcen_d = SRCEN;
                    dsten_d = DSTEN;
                    state_d = first_state(SRCEN, DSTEN);
                end
            end
            S_RSRC: begin
                MEM_RD = 1'b1;
                if (MEM_ACK) begin
                    src_d   = MEM_DIN;
                    ADV_SRC = 1'b1;
                    state_d = dsten_q ? S_RDST : S_WR;
                end
            end
            S_RDST: begin
                MEM_RD  = 1'b1;
                MEM_SEL = 1'b1;
                if (MEM_ACK) begin
                    dst_d   = MEM_DIN;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                MEM_SEL = 1'b1;
                MEM_WR  = !wr_skip;
                if (wr_fire) begin
                    ADV_DST = 1'b1;
                    // Wraps modulo 2**CW, so a loaded 0 runs the full range.
                    cnt_d   = cnt_q - CW'(1);
                    state_d = (cnt_d == '0) ? S_DONE : first_state(srcen_q, dsten_q);
                end
            end
            S_DONE: begin
                DONE    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Result is computed from the next-cycle latch values so a byte read in
        // this cycle is already reflected when the write state is entered. With
        // no reads enabled, WR re-enters itself every byte and refreshes here.
        if ((state_d == S_WR) && ((state_q != S_WR) || wr_fire)) begin
            dout_d = lfu(lfuc_d, src_d, dsten_d ? dst_d : '0);
        end
    end

endmodule

// File: tb/tb_blit_byte_sequencer.sv
// ---------------------------------------------------------------------------
// tb_blit_byte_sequencer
//
// Directed bench for blit_byte_sequencer. A behavioural memory answers
// requests after a programmable number of wait cycles. It serves source and
// destination bytes from tables in request order. A monitor logs write data
// and ADV pulses, and counts handshake violations. These are any RD/WR
// overlap, or a request, select or write-data change before ACK. The main
// sequence compares run length, written bytes and pulse counts against
// hand-computed values. Define BLIT_CMP_INHIBIT_EN to also cover the
// compare-inhibit feature.
// ---------------------------------------------------------------------------
module tb_blit_byte_sequencer;

    localparam int DW = 8;
    localparam int CW = 9;

    logic          CLK       = 1'b0;
    logic          RESET     = 1'b1;
    logic          START     = 1'b0;
    logic [CW-1:0] INNER_CNT = '0;
    logic          SRCEN     = 1'b0;
    logic          DSTEN     = 1'b0;
    logic [3:0]    LFUC      = 4'b0000;
`ifdef BLIT_CMP_INHIBIT_EN
    logic          CMPEN     = 1'b0;
    logic [DW-1:0] CMPVAL    = '0;
`endif
    logic          MEM_RD;
    logic          MEM_WR;
    logic          MEM_SEL;
    logic          MEM_ACK   = 1'b0;
    logic [DW-1:0] MEM_DIN   = '0;
    logic [DW-1:0] MEM_DOUT;
    logic          ADV_SRC;
    logic          ADV_DST;
    logic          BUSY;
    logic          DONE;

    blit_byte_sequencer #(.DW(DW), .CW(CW)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .START     (START),
        .INNER_CNT (INNER_CNT),
        .SRCEN     (SRCEN),
        .DSTEN     (DSTEN),
        .LFUC      (LFUC),
`ifdef BLIT_CMP_INHIBIT_EN
        .CMPEN     (CMPEN),
        .CMPVAL    (CMPVAL),
`endif
        .MEM_RD    (MEM_RD),
        .MEM_WR    (MEM_WR),
        .MEM_SEL   (MEM_SEL),
        .MEM_ACK   (MEM_ACK),
        .MEM_DIN   (MEM_DIN),
        .MEM_DOUT  (MEM_DOUT),
        .ADV_SRC   (ADV_SRC),
        .ADV_DST   (ADV_DST),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    always #5 CLK = ~CLK;

    // ---------------- behavioural memory ----------------
    int            ack_delay  = 0;
    int            wait_cnt   = 0;
    int            src_rd_cnt = 0;
    int            dst_rd_cnt = 0;
    logic [DW-1:0] src_mem [0:1023];
    logic [DW-1:0] dst_mem [0:1023];

    always @(negedge CLK) begin
        if (RESET || !(MEM_RD || MEM_WR)) begin
            MEM_ACK  = 1'b0;
            wait_cnt = 0;
        end else if (wait_cnt < ack_delay) begin
            MEM_ACK  = 1'b0;
            wait_cnt = wait_cnt + 1;
        end else begin
            MEM_ACK  = 1'b1;
            wait_cnt = 0;
            if (MEM_RD) begin
                if (MEM_SEL) begin
                    MEM_DIN    = dst_mem[dst_rd_cnt % 1024];
                    dst_rd_cnt = dst_rd_cnt + 1;
                end else begin
                    MEM_DIN    = src_mem[src_rd_cnt % 1024];
                    src_rd_cnt = src_rd_cnt + 1;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    int            wr_cnt      = 0;
    int            adv_src_cnt = 0;
    int            adv_dst_cnt = 0;
    int            viol_cnt    = 0;
    logic [DW-1:0] wlog [0:1023];
    logic          prev_rd   = 1'b0;
    logic          prev_wr   = 1'b0;
    logic          prev_ack  = 1'b0;
    logic          prev_sel  = 1'b0;
    logic [DW-1:0] prev_dout = '0;

    always @(negedge CLK) begin
        #2;
        if (RESET) begin
            prev_rd  = 1'b0;
            prev_wr  = 1'b0;
            prev_ack = 1'b0;
        end else begin
            if (MEM_RD && MEM_WR) viol_cnt = viol_cnt + 1;
            if ((prev_rd || prev_wr) && !prev_ack) begin
                if (MEM_RD !== prev_rd || MEM_WR !== prev_wr || MEM_SEL !== prev_sel)
                    viol_cnt = viol_cnt + 1;
                if (prev_wr && (MEM_DOUT !== prev_dout))
                    viol_cnt = viol_cnt + 1;
            end
            if (ADV_SRC === 1'b1) adv_src_cnt = adv_src_cnt + 1;
            if (ADV_DST === 1'b1) adv_dst_cnt = adv_dst_cnt + 1;
            if (MEM_WR && MEM_ACK) begin
                wlog[wr_cnt % 1024] = MEM_DOUT;
                wr_cnt = wr_cnt + 1;
            end
            prev_rd   = MEM_RD;
            prev_wr   = MEM_WR;
            prev_ack  = MEM_ACK;
            prev_sel  = MEM_SEL;
            prev_dout = MEM_DOUT;
        end
    end

    // ---------------- checking helpers ----------------
    int vectors     = 0;
    int miscompares = 0;
    int b_wr, b_as, b_ad, b_src, b_dst, b_viol;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
        #3;
    endtask

    task automatic snap();
        b_wr   = wr_cnt;
        b_as   = adv_src_cnt;
        b_ad   = adv_dst_cnt;
        b_src  = src_rd_cnt;
        b_dst  = dst_rd_cnt;
        b_viol = viol_cnt;
    endtask

    // START must already be driven high. Returns the step at which DONE is
    // seen (step 0 = START cycle), or -1 if it never appears. When poke > 0,
    // START is re-pulsed at that step with a different count while the run
    // is busy.
    task automatic run(input int max_steps, input int poke, output int done_step,
                       output logic busy_at_poke);
        done_step    = -1;
        busy_at_poke = 1'b0;
        for (int k = 1; k <= max_steps; k++) begin
            step();
            START = (k == poke);
            if (k == poke) begin
                INNER_CNT    = 9'd7;
                busy_at_poke = BUSY;
            end
            if (DONE === 1'b1) begin
                done_step = k;
                break;
            end
        end
        START = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int   ds;
        logic bp;
        logic found;

        // Reset state
        step();
        step();
        check("rst_mem_rd",  {31'd0, MEM_RD},  32'd0);
        check("rst_mem_wr",  {31'd0, MEM_WR},  32'd0);
        check("rst_mem_sel", {31'd0, MEM_SEL}, 32'd0);
        check("rst_adv_src", {31'd0, ADV_SRC}, 32'd0);
        check("rst_adv_dst", {31'd0, ADV_DST}, 32'd0);
        check("rst_busy",    {31'd0, BUSY},    32'd0);
        check("rst_done",    {31'd0, DONE},    32'd0);
        check("rst_dout",    {24'd0, MEM_DOUT}, 32'h00);
        RESET = 1'b0;
        step();
        check("idle_busy", {31'd0, BUSY}, 32'd0);

        // Copy: src 12,34,56 -> writes 12,34,56; 2 cycles/byte + start + done.
        // START is re-pulsed at step 2 (busy) and must be ignored.
        snap();
        src_mem[(b_src + 0) % 1024] = 8'h12;
        src_mem[(b_src + 1) % 1024] = 8'h34;
        src_mem[(b_src + 2) % 1024] = 8'h56;
        INNER_CNT = 9'd3; SRCEN = 1'b1; DSTEN = 1'b0; LFUC = 4'b1100;
        START = 1'b1;
        run(40, 2, ds, bp);
        check("copy_busy_at_poke", {31'd0, bp}, 32'd1);
        check("copy_done_step", ds, 32'd7);
        check("copy_busy_in_done", {31'd0, BUSY}, 32'd0);
        check("copy_writes", wr_cnt - b_wr, 32'd3);
        check("copy_w0", {24'd0, wlog[(b_wr + 0) % 1024]}, 32'h12);
        check("copy_w1", {24'd0, wlog[(b_wr + 1) % 1024]}, 32'h34);
        check("copy_w2", {24'd0, wlog[(b_wr + 2) % 1024]}, 32'h56);
        check("copy_adv_src", adv_src_cnt - b_as, 32'd3);
        check("copy_adv_dst", adv_dst_cnt - b_ad, 32'd3);
        step();
        check("copy_done_pulse_width", {31'd0, DONE}, 32'd0);
        check("copy_no_restart", {31'd0, BUSY}, 32'd0);

        // XOR with both reads: F0^3C=CC, AA^0F=A5; 3 cycles/byte.
        snap();
        src_mem[(b_src + 0) % 1024] = 8'hF0;
        src_mem[(b_src + 1) % 1024] = 8'hAA;
        dst_mem[(b_dst + 0) % 1024] = 8'h3C;
        dst_mem[(b_dst + 1) % 1024] = 8'h0F;
        INNER_CNT = 9'd2; SRCEN = 1'b1; DSTEN = 1'b1; LFUC = 4'b0110;
        START = 1'b1;
        run(40, 0, ds, bp);
        check("xor_done_step", ds, 32'd7);
        check("xor_writes", wr_cnt - b_wr, 32'd2);
        check("xor_w0", {24'd0, wlog[(b_wr + 0) % 1024]}, 32'hCC);
        check("xor_w1", {24'd0, wlog[(b_wr + 1) % 1024]}, 32'hA5);
        check("xor_dst_reads", dst_rd_cnt - b_dst, 32'd2);
        check("xor_adv_src", adv_src_cnt - b_as, 32'd2);
        step();

        // Wait states: every access ACKed in its third request cycle.
        snap();
        ack_delay = 2;
        src_mem[(b_src + 0) % 1024] = 8'hA1;
        src_mem[(b_src + 1) % 1024] = 8'hB2;
        INNER_CNT = 9'd2; SRCEN = 1'b1; DSTEN = 1'b0; LFUC = 4'b1100;
        START = 1'b1;
        run(60, 0, ds, bp);
        check("wait_done_step", ds, 32'd13);
        check("wait_writes", wr_cnt - b_wr, 32'd2);
        check("wait_w0", {24'd0, wlog[(b_wr + 0) % 1024]}, 32'hA1);
        check("wait_w1", {24'd0, wlog[(b_wr + 1) % 1024]}, 32'hB2);
        check("wait_adv_src", adv_src_cnt - b_as, 32'd2);
        check("wait_adv_dst", adv_dst_cnt - b_ad, 32'd2);
        check("wait_handshake_viol", viol_cnt - b_viol, 32'd0);
        ack_delay = 0;
        step();

        // INNER_CNT=0, no reads: 512 bytes at 1 cycle/byte. LFUC=~S uses the
        // held source latch (last read B2) -> every write is 4D.
        snap();
        INNER_CNT = 9'd0; SRCEN = 1'b0; DSTEN = 1'b0; LFUC = 4'b0011;
        START = 1'b1;
        run(600, 0, ds, bp);
        check("cnt0_done_step", ds, 32'd513);
        check("cnt0_writes", wr_cnt - b_wr, 32'd512);
        check("cnt0_first", {24'd0, wlog[(b_wr + 0) % 1024]}, 32'h4D);
        check("cnt0_last", {24'd0, wlog[(b_wr + 511) % 1024]}, 32'h4D);
        check("cnt0_adv_src", adv_src_cnt - b_as, 32'd0);
        check("cnt0_adv_dst", adv_dst_cnt - b_ad, 32'd512);
        step();

`ifdef BLIT_CMP_INHIBIT_EN
        // Compare inhibit: src 00 matches CMPVAL and is skipped; 07 is written.
        snap();
        CMPEN = 1'b1; CMPVAL = 8'h00;
        src_mem[(b_src + 0) % 1024] = 8'h00;
        src_mem[(b_src + 1) % 1024] = 8'h07;
        INNER_CNT = 9'd2; SRCEN = 1'b1; DSTEN = 1'b0; LFUC = 4'b1100;
        START = 1'b1;
        run(40, 0, ds, bp);
        check("cmp_done_step", ds, 32'd5);
        check("cmp_writes", wr_cnt - b_wr, 32'd1);
        check("cmp_w0", {24'd0, wlog[b_wr % 1024]}, 32'h07);
        check("cmp_adv_dst", adv_dst_cnt - b_ad, 32'd2);
        CMPEN = 1'b0;
        step();
`endif

        // Reset during a destination read with ACK pending.
        snap();
        ack_delay = 3;
        src_mem[(b_src + 0) % 1024] = 8'h11;
        dst_mem[(b_dst + 0) % 1024] = 8'h22;
        INNER_CNT = 9'd2; SRCEN = 1'b1; DSTEN = 1'b1; LFUC = 4'b1100;
        START = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            START = 1'b0;
            if (MEM_RD === 1'b1 && MEM_SEL === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        check("rstmid_reached_rdst", {31'd0, found}, 32'd1);
        check("rstmid_ack_pending", {31'd0, MEM_ACK}, 32'd0);
        RESET = 1'b1;
        #1;
        check("rstmid_mem_rd",  {31'd0, MEM_RD},  32'd0);
        check("rstmid_mem_sel", {31'd0, MEM_SEL}, 32'd0);
        check("rstmid_mem_wr",  {31'd0, MEM_WR},  32'd0);
        check("rstmid_busy",    {31'd0, BUSY},    32'd0);
        check("rstmid_dout",    {24'd0, MEM_DOUT}, 32'h00);
        for (int k = 0; k < 2; k++) begin
            step();
            check("rstmid_no_done", {31'd0, DONE}, 32'd0);
        end
        RESET = 1'b0;
        ack_delay = 0;
        step();
        check("rstmid_idle_done", {31'd0, DONE}, 32'd0);

        // Clean run after reset.
        snap();
        src_mem[(b_src + 0) % 1024] = 8'h5A;
        INNER_CNT = 9'd1; SRCEN = 1'b1; DSTEN = 1'b0; LFUC = 4'b1100;
        START = 1'b1;
        run(20, 0, ds, bp);
        check("post_done_step", ds, 32'd3);
        check("post_writes", wr_cnt - b_wr, 32'd1);
        check("post_w0", {24'd0, wlog[b_wr % 1024]}, 32'h5A);
        step();

        check("handshake_viol_total", viol_cnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
